// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the game-flow controller.
//   gameState_t  : FSM state enum with fixed 3-bit encodings (gameState output)
//   BALL_*       : bit positions of each ball in the ballVisible vector
//   PTS_*        : points awarded when a ball of each size disappears
//   fallPoints() : sums the points for every ball that vanished this cycle
package game_pkg;

  localparam int NUM_BALLS = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    HIT   = 3'd2,
    CLEAR = 3'd3,
    OVER  = 3'd4
  } gameState_t;

  localparam int BALL_HUGE = 0;
  localparam int BALL_BIG1 = 1;
  localparam int BALL_BIG2 = 2;
  localparam int BALL_MED1 = 3;
  localparam int BALL_MED2 = 4;
  localparam int BALL_MED3 = 5;
  localparam int BALL_MED4 = 6;

  localparam logic [7:0] PTS_HUGE   = 8'd10;
  localparam logic [7:0] PTS_BIG    = 8'd20;
  localparam logic [7:0] PTS_MEDIUM = 8'd30;

  // Worst case (all seven fall together) is 10 + 2*20 + 4*30 = 170, fits 8 bits.
  function automatic logic [7:0] fallPoints(input logic [NUM_BALLS-1:0] fell);
    logic [7:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (fell[i]) begin
        if (i == BALL_HUGE)      sum = sum + PTS_HUGE;
        else if (i <= BALL_BIG2) sum = sum + PTS_BIG;
        else                     sum = sum + PTS_MEDIUM;
      end
    end
    return sum;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered rising-edge detector.
//   clk    : system clock
//   resetN : asynchronous active-low reset (history register cleared)
//   d      : level input
//   rise   : high for the cycle in which d is 1 and was 0 on the previous clock
module rise_detect (
  input  logic clk,
  input  logic resetN,
  input  logic d,
  output logic rise
);

  logic prevD;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) prevD <= 1'b0;
    else         prevD <= d;
  end

  assign rise = d & ~prevD;

endmodule

// File: rtl/game_flow_controller.sv
// game_flow_controller: top-level game-flow FSM around the ball controller.
// Tracks score, lives and level, runs the hit-freeze and level-clear pauses
// (counted in startOfFrame pulses) and declares game over.
// Optional build macro LEVEL_TIMER_EN adds a per-level frame budget and the
// timeLeft output; a timeout behaves exactly like a player hit.
// Ports:
//   clk, resetN     : clock, asynchronous active-low reset
//   startOfFrame    : one-cycle pulse per video frame
//   startKey        : start button (level, edge-detected)
//   ballVisible     : per-ball visible flags (bit0 huge, 1-2 big, 3-6 medium)
//   col_player_ball : player/ball collision (level, edge-detected)
//   unitActive      : ball controller enable, high only in PLAY
//   score, lives, level, gameState, gameOver : game status for display
//   timeLeft        : remaining level frames (LEVEL_TIMER_EN only)
module game_flow_controller #(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned HIT_FRAMES   = 60,
  parameter int unsigned CLEAR_FRAMES = 90,
  parameter int unsigned SCORE_MAX    = 9999,
  parameter int unsigned LEVEL_FRAMES = 1800
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        startKey,
  input  logic [6:0]  ballVisible,
  input  logic        col_player_ball,
  output logic        unitActive,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic [3:0]  level,
  output logic [2:0]  gameState,
`ifdef LEVEL_TIMER_EN
  output logic [10:0] timeLeft,
`endif
  output logic        gameOver
);

  import game_pkg::*;

  localparam int CNT_W = $clog2((HIT_FRAMES > CLEAR_FRAMES ? HIT_FRAMES : CLEAR_FRAMES) + 1);
  localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_FRAMES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_FRAMES - 1);

  gameState_t           state, nextState;
  logic [CNT_W-1:0]     frameCnt;
  logic                 armed;
  logic [NUM_BALLS-1:0] prevVis;
  logic                 startRise, colRise;
  logic                 playing, timeout, hitEvt, enterPlay;

  function automatic logic [15:0] satAdd(input logic [15:0] a, input logic [7:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {9'd0, b};
    if (s > 17'(SCORE_MAX)) return 16'(SCORE_MAX);
    return s[15:0];
  endfunction

  rise_detect uStartRise (.clk(clk), .resetN(resetN), .d(startKey),        .rise(startRise));
  rise_detect uColRise   (.clk(clk), .resetN(resetN), .d(col_player_ball), .rise(colRise));

  assign playing   = (state == PLAY);
  assign hitEvt    = playing && (colRise || timeout);
  assign enterPlay = (nextState == PLAY) && (state != PLAY);

`ifdef LEVEL_TIMER_EN
  // Timeout fires on the frame pulse that takes timeLeft to zero.
  assign timeout = playing && startOfFrame && (timeLeft <= 11'd1);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      timeLeft <= 11'(LEVEL_FRAMES);
    end else if (enterPlay && (state != HIT || timeLeft == 11'd0)) begin
      // Fresh budget on every entry except a HIT recovery with time remaining.
      timeLeft <= 11'(LEVEL_FRAMES);
    end else if (playing && startOfFrame && timeLeft != 11'd0) begin
      timeLeft <= timeLeft - 11'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (startRise) nextState = PLAY;
      PLAY: begin
        // A hit outranks a level clear in the same cycle.
        if (hitEvt)                           nextState = (lives <= 3'd1) ? OVER : HIT;
        else if (armed && ballVisible == '0)  nextState = CLEAR;
      end
      HIT:   if (startOfFrame && frameCnt == HIT_LAST)   nextState = PLAY;
      CLEAR: if (startOfFrame && frameCnt == CLEAR_LAST) nextState = PLAY;
      OVER:  if (startRise) nextState = PLAY;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      frameCnt <= '0;
      armed    <= 1'b0;
      prevVis  <= '0;
      score    <= '0;
      lives    <= 3'(LIVES_INIT);
      level    <= 4'd1;
    end else begin
      state   <= nextState;
      prevVis <= ballVisible;

      if (nextState != state)
        frameCnt <= '0;
      else if ((state == HIT || state == CLEAR) && startOfFrame)
        frameCnt <= frameCnt + CNT_W'(1);

      // Balls vanishing outside PLAY are the controller clearing them, not kills.
      if (playing)
        score <= satAdd(score, fallPoints(prevVis & ~ballVisible));

      // armed waits for the first deployed ball so the empty field right after
      // entry (controller deploy latency) is not mistaken for a cleared level.
      if (enterPlay)                   armed <= 1'b0;
      else if (playing && |ballVisible) armed <= 1'b1;

      if (hitEvt) lives <= lives - 3'd1;

      if ((state == IDLE || state == OVER) && startRise) begin
        score <= '0;
        lives <= 3'(LIVES_INIT);
        level <= 4'd1;
      end

      if (state == CLEAR && nextState == PLAY && level != 4'd15)
        level <= level + 4'd1;
    end
  end

  assign unitActive = playing;
  assign gameOver   = (state == OVER);
  assign gameState  = state;

endmodule

// File: tb/tb_game_flow_controller.sv
module tb_game_flow_controller;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        startKey = 1'b0;
  logic [6:0]  ballVisible = '0;
  logic        colPB = 1'b0;
  logic        unitActive, gameOver;
  logic [15:0] score;
  logic [2:0]  lives, gameState;
  logic [3:0]  level;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

`ifdef LEVEL_TIMER_EN
  logic [10:0] timeLeft;
`endif

  game_flow_controller #(
    .LIVES_INIT(3), .HIT_FRAMES(60), .CLEAR_FRAMES(90), .SCORE_MAX(100), .LEVEL_FRAMES(1800)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startKey(startKey),
    .ballVisible(ballVisible), .col_player_ball(colPB), .unitActive(unitActive),
    .score(score), .lives(lives), .level(level), .gameState(gameState),
`ifdef LEVEL_TIMER_EN
    .timeLeft(timeLeft),
`endif
    .gameOver(gameOver)
  );

`ifdef LEVEL_TIMER_EN
  logic        tSof = 1'b0, tStart = 1'b0;
  logic [6:0]  tVis = '0;
  logic        tCol = 1'b0;
  logic        tActive, tOver;
  logic [15:0] tScore;
  logic [2:0]  tLives, tState;
  logic [3:0]  tLevel;
  logic [10:0] tTime;

  game_flow_controller #(
    .LIVES_INIT(3), .HIT_FRAMES(60), .CLEAR_FRAMES(90), .SCORE_MAX(9999), .LEVEL_FRAMES(5)
  ) tdut (
    .clk(clk), .resetN(resetN), .startOfFrame(tSof), .startKey(tStart),
    .ballVisible(tVis), .col_player_ball(tCol), .unitActive(tActive),
    .score(tScore), .lives(tLives), .level(tLevel), .gameState(tState),
    .timeLeft(tTime), .gameOver(tOver)
  );

  task automatic tFrames(input int n);
    repeat (n) begin
      tSof = 1'b1; @(negedge clk);
      tSof = 1'b0; @(negedge clk);
    end
  endtask
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1; @(negedge clk);
      startOfFrame = 1'b0; @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step(2);
    check("rst_state", gameState, 0);
    check("rst_active", unitActive, 0);
    check("rst_score", score, 0);
    check("rst_lives", lives, 3);
    check("rst_level", level, 1);
    check("rst_over", gameOver, 0);
    resetN = 1'b1;
    step(1);

    // Held start key: one start only
    startKey = 1'b1;
    step(1);
    check("start_state", gameState, 1);
    check("start_active", unitActive, 1);
    step(99);
    check("start_held", gameState, 1);
    startKey = 1'b0;
    step(1);

    // Scoring: huge falls (+10), then both bigs together (+40)
    ballVisible = 7'b0000001; step(1);
    check("score_init", score, 0);
    ballVisible = 7'b0000110; step(1);
    check("score_huge", score, 10);
    ballVisible = 7'b1000000; step(1);
    check("score_bigs", score, 50);
    check("score_state", gameState, 1);

    // Hit 1 with a long collision
    colPB = 1'b1; step(1);
    check("hit1_lives", lives, 2);
    check("hit1_state", gameState, 2);
    check("hit1_active", unitActive, 0);
    step(19);
    check("hit1_held", lives, 2);
    colPB = 1'b0; ballVisible = '0; step(1);
    check("hit1_nofall", score, 50);
    frames(59);
    check("hit1_59", gameState, 2);
    frames(1);
    check("hit1_back", gameState, 1);
    check("hit1_score", score, 50);
    check("hit1_level", level, 1);

    // Unarmed empty field stays in PLAY; hits 2 and 3
    step(3);
    check("unarmed", gameState, 1);
    colPB = 1'b1; step(1);
    check("hit2_lives", lives, 1);
    check("hit2_state", gameState, 2);
    colPB = 1'b0;
    frames(60);
    check("hit2_back", gameState, 1);
    colPB = 1'b1; step(1);
    check("over_lives", lives, 0);
    check("over_state", gameState, 4);
    check("over_flag", gameOver, 1);
    check("over_active", unitActive, 0);
    colPB = 1'b0; step(2);

    // Restart from OVER reloads
    startKey = 1'b1; step(1);
    check("restart_state", gameState, 1);
    check("restart_score", score, 0);
    check("restart_lives", lives, 3);
    check("restart_level", level, 1);
    startKey = 1'b0;

    // Arming and level clear
    step(2);
    check("arm_wait", gameState, 1);
    ballVisible = 7'b0000001; step(1);
    check("arm_set", gameState, 1);
    ballVisible = '0; step(1);
    check("clear_state", gameState, 3);
    check("clear_score", score, 10);
    frames(89);
    check("clear_89", gameState, 3);
    frames(1);
    check("clear_back", gameState, 1);
    check("clear_level", level, 2);

    // Hit beats clear, score still applies
    ballVisible = 7'b0001000; step(1);
    ballVisible = '0; colPB = 1'b1; step(1);
    check("prio_state", gameState, 2);
    check("prio_score", score, 40);
    check("prio_lives", lives, 2);
    colPB = 1'b0;
    frames(60);
    check("prio_back", gameState, 1);
    check("prio_level", level, 2);

    // Asynchronous reset mid-PLAY
    #2;
    resetN = 1'b0;
    #1;
    check("arst_state", gameState, 0);
    check("arst_active", unitActive, 0);
    check("arst_score", score, 0);
    check("arst_lives", lives, 3);
    check("arst_level", level, 1);
    step(1);
    resetN = 1'b1;
    step(1);

    // Score saturation (SCORE_MAX = 100 here)
    startKey = 1'b1; step(1);
    startKey = 1'b0;
    ballVisible = 7'h7F; step(1);
    ballVisible = 7'b1000000; step(1);
    check("sat_score", score, 100);
    ballVisible = '0; step(1);
    check("sat_hold", score, 100);
    check("sat_clear", gameState, 3);

`ifdef LEVEL_TIMER_EN
    // Level timer with a 5-frame budget
    tStart = 1'b1; step(1);
    tStart = 1'b0;
    check("tmr_state", tState, 1);
    check("tmr_load", tTime, 5);
    tFrames(4);
    check("tmr_dec", tTime, 1);
    check("tmr_play", tState, 1);
    tFrames(1);
    check("tmr_hit", tState, 2);
    check("tmr_lives", tLives, 2);
    tFrames(60);
    check("tmr_back", tState, 1);
    check("tmr_reload", tTime, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
Top-level game-flow FSM directly upstream and downstream of the ball controller. Drives its unitActive enable and consumes its seven ball-visible flags plus the merged col_player_ball collision. Tracks score, lives and level, runs the hit-freeze and level-clear pauses, and declares game over. All timing is in frames, using the startOfFrame strobe.

Parameters:
LIVES_INIT, 3, lives loaded at game start (1..7)
HIT_FRAMES, 60, frames of freeze after the player is hit
CLEAR_FRAMES, 90, frames of pause after a level is cleared
SCORE_MAX, 9999, score saturation value
LEVEL_FRAMES, 1800, level time budget in frames (only with LEVEL_TIMER_EN)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per video frame
startKey  in  1  start button, level signal, may be held
ballVisible  in  7  bit0 huge, bits1-2 big1/big2, bits3-6 medium1..4
col_player_ball  in  1  merged player/ball collision, level, may last many cycles
unitActive  out  1  enable to the ball controller
score  out  16  binary score
lives  out  3  remaining lives
level  out  4  current level, starts at 1
gameState  out  3  encoded FSM state, for display muxing
gameOver  out  1  high in OVER state
timeLeft  out  11  remaining level frames (only with LEVEL_TIMER_EN, else port absent)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, resetN).
- Reset values: state IDLE, unitActive 0, score 0, lives LIVES_INIT, level 1, gameOver 0, frame counter 0, armed 0, all edge-detect history registers 0.
- Edge detection: startKey and col_player_ball are edge-detected (registered previous value). Only rising edges act; a held level is one event.
- States:
  - IDLE: unitActive 0. On startKey rise -> PLAY; load score 0, lives LIVES_INIT, level 1.
  - PLAY: unitActive 1.
  - HIT: unitActive 0. Counter counts startOfFrame pulses. At HIT_FRAMES -> PLAY; level and score kept, balls redeployed.
  - CLEAR: unitActive 0. Counts CLEAR_FRAMES, then level <= level+1 (saturate at 15) -> PLAY.
  - OVER: gameOver 1, unitActive 0. startKey rise -> PLAY with score, lives and level reloaded.
- Arming: armed is cleared on every entry to PLAY and set when any ballVisible bit is 1 while in PLAY. This covers the 2-cycle deploy latency of the ball controller.
- Scoring: in PLAY, every ballVisible bit with a 1->0 transition (registered previous vector) adds points: bit0 +10, bits1-2 +20, bits3-6 +30.
  - Simultaneous falls in one cycle are summed.
  - The result saturates at SCORE_MAX.
  - Falls outside PLAY (deactivation clearing) are ignored.
  - The previous-vector register is updated every cycle.
- Player hit: col_player_ball rise in PLAY decrements lives. If the result is 0 -> OVER, else -> HIT. The counter resets on entry.
- Level clear: in PLAY with armed=1 and ballVisible==0 -> CLEAR.
- Priority in one cycle: score update always applies; hit beats clear.
- startKey in PLAY, HIT or CLEAR is ignored.
- startOfFrame outside HIT or CLEAR has no effect on the counter.
- Counter is cleared on every state change.

Optional Feature:
LEVEL_TIMER_EN:
- Defined: timeLeft loads LEVEL_FRAMES on every PLAY entry from IDLE, OVER or CLEAR, and is held through HIT. It decrements per startOfFrame in PLAY. Reaching 0 is treated exactly as a player hit, at the same priority. After a HIT caused by timeout, timeLeft reloads.
- Undefined: no timer logic and no timeLeft port; levels are untimed.

Decomposition:
- Package game_pkg: state enum (IDLE, PLAY, HIT, CLEAR, OVER) with fixed 3-bit encodings for gameState; ball index constants; point constants PTS_HUGE, PTS_BIG, PTS_MEDIUM; NUM_BALLS=7.
- Sub-module rise_detect: 1-bit registered rising-edge detector with async active-low reset, instantiated for startKey and col_player_ball.

Test Plan:
- Reset mid-PLAY with score 40: assert resetN low -> state IDLE, unitActive 0, score 0, lives 3, level 1 immediately, without waiting for a clock edge.
- startKey held for 100 cycles from IDLE -> exactly one transition to PLAY; unitActive 1 on the next cycle; no second start.
- In PLAY, ballVisible 7'b0000001 -> 7'b0000110, then bits 1 and 2 falling in the same cycle -> score +10 then +40, total 50.
- col_player_ball held for 20 cycles with lives 3 -> lives 2, HIT, unitActive 0. After 60 startOfFrame pulses -> PLAY. Repeat twice more -> lives 0, OVER, gameOver 1.
- Entry to PLAY with ballVisible 0 for 2 cycles, then 1, then all bits cleared -> no CLEAR before arming. CLEAR after the clear; 90 frames later level 2, PLAY.
- Same cycle as the last ball falls, col_player_ball rises -> score updated and HIT entered, not CLEAR.
- With LEVEL_TIMER_EN and LEVEL_FRAMES=5: 5 startOfFrame pulses in PLAY -> lives decrements, HIT; timeLeft reloads to 5 on return to PLAY.
